key_step_gen: RTL and testbench

Push-button conditioner feeding the enable/direction inputs of the up/down decade counter (`EN_UDCNT10`). It takes two raw active-low keys (step up, step down) and synchronizes and debounces them. It outputs a single-cycle `EN` pulse per accepted press, plus auto-repeat pulses while a key is held, and a registered `UP` level giving the direction of the most recent accepted press. `EN` and `UP` connect directly to the counter's `EN` and `UP` ports on the same `CLK`.

---
 rtl/key_step_gen_if.sv | 9 +
 rtl/key_step_gen.sv | 81 ++++++++
 tb/tb_key_step_gen.sv | 124 ++++++++++++
 3 files changed

// File: rtl/key_step_gen_if.sv
// key_step_gen_if: raw key inputs and EN/UP step outputs of the key conditioner.
interface key_step_gen_if;
   logic KEY_UP_B;
   logic KEY_DN_B;
   logic EN;
   logic UP;
   modport master (output KEY_UP_B, KEY_DN_B, input EN, UP);
   modport slave (input KEY_UP_B, KEY_DN_B, output EN, UP);
endinterface

// File: rtl/key_step_gen.sv
// key_step_gen: synchronizes and debounces two active-low keys into EN step pulses with auto-repeat and a UP direction level.
module key_step_gen #(
   parameter int DEB_CYC    = 1000,
   parameter int REP_DELAY  = 50000,
   parameter int REP_PERIOD = 10000,
   parameter int CNT_W      = 16
) (
   input logic          CLK,
   input logic          RESET_B,
   key_step_gen_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2, LOCK = 2'd3;
   logic [1:0]       r_sync_up, r_sync_dn, r_state;
   logic             r_d_up, r_d_dn, r_en, r_up;
   logic [CNT_W-1:0] r_dc_up, r_dc_dn, r_t;
   logic             w_lvl_up, w_lvl_dn, w_tgl_up, w_tgl_dn;
   logic             w_rise_up, w_rise_dn, w_fall_up, w_fall_dn;
   logic             w_fall_act, w_rise_oth, w_rep_hit;
   assign w_lvl_up   = ~r_sync_up[1];
   assign w_lvl_dn   = ~r_sync_dn[1];
   assign w_tgl_up   = (w_lvl_up != r_d_up) && (r_dc_up == CNT_W'(DEB_CYC - 1));
   assign w_tgl_dn   = (w_lvl_dn != r_d_dn) && (r_dc_dn == CNT_W'(DEB_CYC - 1));
   assign w_rise_up  = w_tgl_up & ~r_d_up;
   assign w_rise_dn  = w_tgl_dn & ~r_d_dn;
   assign w_fall_up  = w_tgl_up & r_d_up;
   assign w_fall_dn  = w_tgl_dn & r_d_dn;
   // r_up always names the key that started the current press
   assign w_fall_act = r_up ? w_fall_up : w_fall_dn;
   assign w_rise_oth = r_up ? w_rise_dn : w_rise_up;
   assign w_rep_hit  = r_t == CNT_W'((r_state == HOLD) ? REP_DELAY - 1 : REP_PERIOD - 1);
   assign bus.EN     = r_en;
   assign bus.UP     = r_up;
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         r_sync_up <= 2'b11;
         r_sync_dn <= 2'b11;
         r_d_up    <= 1'b0;
         r_d_dn    <= 1'b0;
         r_dc_up   <= '0;
         r_dc_dn   <= '0;
      end else begin
         r_sync_up <= {r_sync_up[0], bus.KEY_UP_B};
         r_sync_dn <= {r_sync_dn[0], bus.KEY_DN_B};
         r_d_up    <= r_d_up ^ w_tgl_up;
         r_d_dn    <= r_d_dn ^ w_tgl_dn;
         r_dc_up   <= (w_lvl_up == r_d_up || w_tgl_up) ? '0 : r_dc_up + 1'b1;
         r_dc_dn   <= (w_lvl_dn == r_d_dn || w_tgl_dn) ? '0 : r_dc_dn + 1'b1;
      end
   end
   // release and lock outrank the timer pulse on the same edge
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         r_state <= IDLE;
         r_en    <= 1'b0;
         r_up    <= 1'b1;
         r_t     <= '0;
      end else begin
         r_en <= 1'b0;
         case (r_state)
            IDLE:
               if (w_rise_up && w_rise_dn) r_state <= LOCK;
               else if (w_rise_up || w_rise_dn) begin
                  r_en    <= 1'b1;
                  r_up    <= w_rise_up;
                  r_t     <= '0;
                  r_state <= HOLD;
               end
            HOLD, REPEAT:
               if (w_fall_act) r_state <= IDLE;
               else if (w_rise_oth) r_state <= LOCK;
               else if (w_rep_hit) begin
                  r_en    <= 1'b1;
                  r_t     <= '0;
                  r_state <= REPEAT;
               end else r_t <= r_t + 1'b1;
            default:
               if (!r_d_up && !r_d_dn) r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_key_step_gen.sv
// tb_key_step_gen: directed checks of press latency, debounce, auto-repeat, lock and a decade counter driven by EN/UP.
module tb_key_step_gen;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   int         n_chk = 0, n_err = 0, n_pulse = 0;
   logic [3:0] q;
   logic [63:0] m;
   key_step_gen_if bus ();
   key_step_gen #(.DEB_CYC(4), .REP_DELAY(16), .REP_PERIOD(4), .CNT_W(8)) dut (
      .CLK(clk), .RESET_B(rst_n), .bus(bus)
   );
   always #5 clk = ~clk;
   // decade up/down counter fed by EN/UP
   always @(posedge clk or negedge rst_n)
      if (!rst_n) q <= 4'd0;
      else if (bus.EN) q <= bus.UP ? ((q == 4'd9) ? 4'd0 : q + 4'd1) : ((q == 4'd0) ? 4'd9 : q - 4'd1);
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // edge k of a run is the k-th rising edge after the inputs were set
   task automatic run(input string tag, input int n, input logic [63:0] exp_mask);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         check(tag, 32'(bus.EN), 32'(exp_mask[k]));
         if (bus.EN) n_pulse++;
      end
   endtask
   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_en", 32'(bus.EN), 32'd0);
      check("rst_up", 32'(bus.UP), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask
   initial begin
      bus.KEY_UP_B = 1'b1;
      bus.KEY_DN_B = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_en", 32'(bus.EN), 32'd0);
      check("reset_up", 32'(bus.UP), 32'd1);
      rst_n = 1'b1;
      run("idle", 4, 64'h0);
      bus.KEY_UP_B = 1'b0;
      run("up_press", 10, 64'h20);
      check("up_dir", 32'(bus.UP), 32'd1);
      bus.KEY_UP_B = 1'b1;
      run("up_release", 10, 64'h0);
      bus.KEY_DN_B = 1'b0;
      run("dn_press", 6, 64'h20);
      check("dn_dir", 32'(bus.UP), 32'd0);
      rst_n = 1'b0;
      bus.KEY_DN_B = 1'b1;
      bus.KEY_UP_B = 1'b0;
      #1;
      check("async_rst_en", 32'(bus.EN), 32'd0);
      check("async_rst_up", 32'(bus.UP), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run("post_rst_press", 8, 64'h20);
      check("post_rst_dir", 32'(bus.UP), 32'd1);
      bus.KEY_UP_B = 1'b1;
      run("post_rst_release", 12, 64'h0);
      for (int i = 0; i < 10; i++) begin
         bus.KEY_DN_B = i[0];
         run("bounce", 2, 64'h0);
      end
      bus.KEY_DN_B = 1'b1;
      run("bounce_settle", 8, 64'h0);
      check("bounce_dir", 32'(bus.UP), 32'd1);
      bus.KEY_UP_B = 1'b0;
      run("repeat_hold", 40, 64'h00000022_22200020);
      bus.KEY_UP_B = 1'b1;
      run("repeat_release", 16, 64'h2);
      bus.KEY_UP_B = 1'b0;
      bus.KEY_DN_B = 1'b0;
      run("lock_both", 10, 64'h0);
      bus.KEY_UP_B = 1'b1;
      run("lock_up_rel", 10, 64'h0);
      bus.KEY_DN_B = 1'b1;
      run("lock_both_rel", 8, 64'h0);
      bus.KEY_DN_B = 1'b0;
      run("unlock_dn", 8, 64'h20);
      check("unlock_dir", 32'(bus.UP), 32'd0);
      bus.KEY_DN_B = 1'b1;
      run("unlock_rel", 8, 64'h0);
      bus.KEY_UP_B = 1'b0;
      run("rep_lock_a", 22, 64'h200020);
      bus.KEY_DN_B = 1'b0;
      run("rep_lock_b", 16, 64'h8);
      bus.KEY_UP_B = 1'b1;
      bus.KEY_DN_B = 1'b1;
      run("rep_lock_rel", 10, 64'h0);
      do_reset();
      check("cnt_zero", 32'(q), 32'd0);
      n_pulse = 0;
      m = 64'h20;
      for (int i = 21; i < 60; i += 4) m[i] = 1'b1;
      bus.KEY_UP_B = 1'b0;
      run("cnt_up_hold", 60, m);
      bus.KEY_UP_B = 1'b1;
      run("cnt_up_rel", 15, 64'h2);
      check("cnt_up_pulses", 32'(n_pulse), 32'd12);
      check("cnt_up_q", 32'(q), 32'd2);
      for (int i = 0; i < 3; i++) begin
         bus.KEY_DN_B = 1'b0;
         run("cnt_dn_press", 8, 64'h20);
         bus.KEY_DN_B = 1'b1;
         run("cnt_dn_rel", 10, 64'h0);
      end
      check("cnt_dn_q", 32'(q), 32'd9);
      check("cnt_dn_dir", 32'(bus.UP), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
